vga_sync_decoder: RTL and testbench

//  Receive side of the 640x480 VGA pixel interface. Samples a driven VGA stream
//  (RGB, active-low hs/vs, blank_n) on the system clock, one sample per pix_en strobe.

---
 rtl/vga_sync_decoder.sv | 223 ++++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// VGA receive-side decoder: rebuilds px/py/pixel from a sampled sync stream
// and verifies line/frame timing before declaring lock.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic        in_blank_n,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  input  logic        err_clr,
  output logic [9:0]  px,
  output logic [9:0]  py,
  output logic        de,
  output logic [23:0] pixel,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err
);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_ALIGN  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [10:0] HT = 11'(H_TOTAL);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [9:0]  VT = 10'(V_TOTAL);
  localparam logic [9:0]  VA = 10'(V_ACTIVE);
  localparam logic [3:0]  LF = 4'(LOCK_FRAMES);

  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        bl_q, bl_d;
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [9:0]  px_q, px_d;
  logic [9:0]  py_q, py_d;
  logic        de_q, de_d;
  logic [23:0] pixel_q, pixel_d;
  logic [1:0]  state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic        frame_bad_q, frame_bad_d;
  logic        locked_q, locked_d;
  logic        h_err_q, h_err_d;
  logic        v_err_q, v_err_d;

  logic        hs_fall;
  logic        vs_fall;
  logic        bl_fall;
  logic        act;
  logic        chk;
  logic [10:0] hcnt_nxt;
  logic [10:0] run_len;
  logic [9:0]  vcnt_line;
  logic [9:0]  py_cnt;
  logic        h_mis;
  logic        v_mis;

  // edges are taken against the previous pix_en sample only
  always_comb begin
    hs_fall  = pix_en & hs_q & ~in_hs;
    vs_fall  = pix_en & vs_q & ~in_vs;
    bl_fall  = pix_en & bl_q & ~in_blank_n;
    act      = pix_en & in_blank_n;
    chk      = (state_q != S_SEARCH);
    hcnt_nxt = {1'b0, hcnt_q} + 11'd1;
    run_len  = {1'b0, px_q} + 11'd1;
  end

  always_comb begin
    h_mis = 1'b0;
    if (hs_fall && (hcnt_q == 10'h3ff || hcnt_nxt != HT))
      h_mis = 1'b1;
    if (pix_en && !hs_fall && hcnt_q == 10'h3fe)
      h_mis = 1'b1;
    if (bl_fall && run_len != HA)
      h_mis = 1'b1;
  end

  // a line ending on the same sample as vs is counted before the frame check
  always_comb begin
    vcnt_line = vcnt_q;
    if (hs_fall && vcnt_q != 10'h3ff)
      vcnt_line = vcnt_q + 10'd1;
    py_cnt = bl_fall ? py_q + 10'd1 : py_q;
    v_mis  = vs_fall & ((vcnt_line != VT) | (py_cnt != VA));
  end

  always_comb begin
    hs_d    = pix_en ? in_hs : hs_q;
    vs_d    = pix_en ? in_vs : vs_q;
    bl_d    = pix_en ? in_blank_n : bl_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    px_d    = px_q;
    py_d    = py_q;
    de_d    = act;
    pixel_d = pixel_q;
    if (pix_en) begin
      if (hs_fall)
        hcnt_d = 10'd0;
      else if (hcnt_q != 10'h3ff)
        hcnt_d = hcnt_q + 10'd1;
      vcnt_d = vs_fall ? 10'd0 : vcnt_line;
      if (act)
        px_d = bl_q ? px_q + 10'd1 : 10'd0;
      if (vs_fall)
        py_d = 10'd0;
      else
        py_d = py_cnt;
    end
    if (act)
      pixel_d = {in_r, in_g, in_b};
  end

  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    frame_bad_d = frame_bad_q | (chk & h_mis);
    unique case (1'b1)
      (state_q == S_ALIGN): begin
        if (vs_fall) begin
          frame_bad_d = 1'b0;
          if (frame_bad_q || h_mis || v_mis) begin
            good_d = 4'd0;
          end else if (good_q + 4'd1 >= LF) begin
            good_d  = 4'd0;
            state_d = S_LOCKED;
          end else begin
            good_d = good_q + 4'd1;
          end
        end
      end
      (state_q == S_LOCKED): begin
        if (h_mis || v_mis) begin
          state_d     = S_SEARCH;
          frame_bad_d = 1'b0;
        end else if (vs_fall) begin
          frame_bad_d = 1'b0;
        end
      end
      default: begin
        frame_bad_d = 1'b0;
        if (vs_fall) begin
          state_d = S_ALIGN;
          good_d  = 4'd0;
        end else begin
          state_d = S_SEARCH;
        end
      end
    endcase
    locked_d = (state_d == S_LOCKED);
  end

  // a fresh mismatch outranks a simultaneous clear
  always_comb begin
    h_err_d = h_err_q;
    v_err_d = v_err_q;
    if (err_clr) begin
      h_err_d = 1'b0;
      v_err_d = 1'b0;
    end
    if (chk && h_mis)
      h_err_d = 1'b1;
    if (chk && v_mis)
      v_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      bl_q        <= 1'b0;
      hcnt_q      <= 10'd0;
      vcnt_q      <= 10'd0;
      px_q        <= 10'd0;
      py_q        <= 10'd0;
      de_q        <= 1'b0;
      pixel_q     <= 24'd0;
      state_q     <= S_SEARCH;
      good_q      <= 4'd0;
      frame_bad_q <= 1'b0;
      locked_q    <= 1'b0;
      h_err_q     <= 1'b0;
      v_err_q     <= 1'b0;
    end else begin
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      bl_q        <= bl_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      px_q        <= px_d;
      py_q        <= py_d;
      de_q        <= de_d;
      pixel_q     <= pixel_d;
      state_q     <= state_d;
      good_q      <= good_d;
      frame_bad_q <= frame_bad_d;
      locked_q    <= locked_d;
      h_err_q     <= h_err_d;
      v_err_q     <= v_err_d;
    end
  end

  assign px          = px_q;
  assign py          = py_q;
  assign de          = de_q;
  assign pixel       = pixel_q;
  assign locked      = locked_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign frame_start = de_q & (px_q == 10'd0) & (py_q == 10'd0) & locked_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down 16x6 raster (24x10 totals);
// pixel outputs are checked through a scoreboard, status flags by direct checks.
module tb_vga_sync_decoder;

  localparam int HA  = 16;
  localparam int HT  = 24;
  localparam int VA  = 6;
  localparam int VT  = 10;
  localparam int HS0 = 18;
  localparam int HS1 = 22;
  localparam int VS0 = 7;
  localparam int VS1 = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;
  logic in_hs = 1'b1;
  logic in_vs = 1'b1;
  logic in_blank_n = 1'b0;
  logic err_clr = 1'b0;
  logic [7:0] in_r = 8'd0;
  logic [7:0] in_g = 8'd0;
  logic [7:0] in_b = 8'd0;
  logic [9:0] px, py;
  logic de;
  logic [23:0] pixel;
  logic frame_start, locked, h_err, v_err;

  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] p;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic       m_bl = 1'b0;
  logic       m_vs = 1'b0;
  logic [9:0] m_px = 10'd0;
  logic [9:0] m_py = 10'd0;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA),
    .V_TOTAL(VT), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .in_hs(in_hs), .in_vs(in_vs), .in_blank_n(in_blank_n),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .err_clr(err_clr),
    .px(px), .py(py), .de(de), .pixel(pixel),
    .frame_start(frame_start), .locked(locked),
    .h_err(h_err), .v_err(v_err)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h @%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (frame_start)
      fs_cnt++;
    if (de) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty got de=1 px=%0d py=%0d want no output", px, py);
      end else begin
        mon_e = sb.pop_front();
        if ({px, py, pixel} !== mon_e) begin
          errors++;
          $display("FAIL sb_pixel got %0d,%0d,%06h want %0d,%0d,%06h",
                   px, py, pixel, mon_e.x, mon_e.y, mon_e.p);
        end
      end
    end
  end

  task automatic tick(input logic hs, input logic vs, input logic bl,
                      input logic [7:0] g, input logic [7:0] b,
                      input logic clr, input logic rst);
    @(negedge clk);
    pix_en     = 1'b1;
    in_hs      = hs;
    in_vs      = vs;
    in_blank_n = bl;
    in_r       = 8'd0;
    in_g       = g;
    in_b       = b;
    err_clr    = clr;
    reset      = rst;
    if (rst) begin
      m_bl = 1'b0;
      m_vs = 1'b0;
      m_px = 10'd0;
      m_py = 10'd0;
    end else begin
      if (bl) begin
        m_px = m_bl ? m_px + 10'd1 : 10'd0;
        sb.push_back({m_px, m_py, 8'h00, g, b});
      end
      if (m_bl && !bl)
        m_py = m_py + 10'd1;
      if (m_vs && !vs)
        m_py = 10'd0;
      m_bl = bl;
      m_vs = vs;
    end
    @(negedge clk);
    pix_en  = 1'b0;
    err_clr = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic line(input int y, input int len = HT,
                      input int clr_at = -1, input int gap_at = -1,
                      input int rst_at = -1);
    for (int t = 0; t < len; t++) begin
      if (t == gap_at) begin
        repeat (50) @(negedge clk);
        check("gap_de", de, 0);
        check("gap_px", px, m_px);
      end
      tick(!(t >= HS0 && t < HS1), !(y >= VS0 && y < VS1),
           (y < VA) && (t < HA), 8'(t), 8'(y),
           t == clr_at, t == rst_at);
      if (t == rst_at) begin
        check("rst_px", px, 0);
        check("rst_py", py, 0);
        check("rst_pixel", pixel, 0);
        check("rst_de", de, 0);
        check("rst_fs", frame_start, 0);
        check("rst_locked", locked, 0);
        check("rst_herr", h_err, 0);
        check("rst_verr", v_err, 0);
      end
    end
  endtask

  task automatic frame(input int nl = VT, input int short_y = -1,
                       input int clr_y = -1, input int gap_y = -1);
    for (int y = 0; y < nl; y++)
      line(y, (y == short_y) ? HT - 1 : HT,
           (y == clr_y) ? HS0 : -1, (y == gap_y) ? 5 : -1, -1);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("init_px", px, 0);
    check("init_py", py, 0);
    check("init_de", de, 0);
    check("init_pixel", pixel, 0);
    check("init_locked", locked, 0);
    check("init_herr", h_err, 0);
    check("init_verr", v_err, 0);
    reset = 1'b0;

    // ideal stream: lock at the third vs fall
    frame();
    check("f0_locked", locked, 0);
    frame();
    check("f1_locked", locked, 0);
    for (int y = 0; y < VS0; y++) line(y);
    check("f2_pre_vs_locked", locked, 0);
    for (int y = VS0; y < VT; y++) line(y);
    check("f2_locked", locked, 1);
    check("f2_fs", fs_cnt, 0);
    check("f2_herr", h_err, 0);
    check("f2_verr", v_err, 0);

    // short line drops lock
    frame();
    frame(VT, 2);
    check("f4_fs", fs_cnt, 2);
    check("f4_herr", h_err, 1);
    check("f4_locked", locked, 0);
    pulse_clr();
    check("clr_herr", h_err, 0);
    frame();
    check("f5_locked", locked, 0);
    frame();
    check("f6_locked", locked, 1);
    check("f6_herr", h_err, 0);

    // short frame
    frame(VT - 1);
    frame();
    check("f8_verr", v_err, 1);
    check("f8_locked", locked, 0);
    pulse_clr();
    check("clr_verr", v_err, 0);
    frame();
    frame();
    frame();
    check("f11_verr", v_err, 0);
    check("f11_herr", h_err, 0);
    check("f11_locked", locked, 1);

    // reset mid-frame
    for (int y = 0; y < 3; y++) line(y);
    line(3, HT, -1, -1, 5);
    for (int y = 4; y < VT; y++) line(y);
    check("f12_herr", h_err, 0);
    check("f12_verr", v_err, 0);
    check("f12_locked", locked, 0);
    frame();
    check("f13_locked", locked, 0);
    frame();
    check("f14_locked", locked, 1);
    check("f14_herr", h_err, 0);
    check("f14_verr", v_err, 0);

    // pix_en gap mid-line, then clear racing a new error
    frame(VT, -1, -1, 2);
    check("f15_herr", h_err, 0);
    check("f15_locked", locked, 1);
    frame(VT, 1, 2);
    check("f16_herr", h_err, 1);
    pulse_clr();
    check("f16_clr_herr", h_err, 0);

    repeat (4) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
